pcpi_initiator: RTL and testbench
=================================

PCPI_INITIATOR -- requirements
Module: pcpi_initiator

Interface
REQ-001 SHALL have parameter NUM_TXN, default 100, meaning transactions per run (1..65535).
REQ-002 SHALL have parameter GAP, default 10, meaning idle cycles before each request (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum count of non-wait cycles to wait for ready.
REQ-004 SHALL have parameter SEED, default 314159265, meaning the xorshift32 initial state (nonzero).
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: start  in  1  begin run (pulse).
REQ-008 SHALL have port: pcpi_valid  out  1  request valid.
REQ-009 SHALL have port: pcpi_insn  out  32  instruction word.
REQ-010 SHALL have port: pcpi_rs1  out  32  operand 1.
REQ-011 SHALL have port: pcpi_rs2  out  32  operand 2.
REQ-012 SHALL have port: pcpi_wr  in  1  responder writes pcpi_rd.
REQ-013 SHALL have port: pcpi_rd  in  32  result.
REQ-014 SHALL have port: pcpi_wait  in  1  responder busy; freezes the timeout count.
REQ-015 SHALL have port: pcpi_ready  in  1  responder completion.
REQ-016 SHALL have port: busy  out  1  run in progress.
REQ-017 SHALL have port: done  out  1  run complete (level).
REQ-018 SHALL have port: timeout_err  out  1  sticky; a request timed out.
REQ-019 SHALL have port: txn_count  out  16  completed transactions.
REQ-020 SHALL have port: checksum  out  32  folded result signature.

Function
REQ-021 SHALL implement FSM IDLE, GAP, REQ, DONE.
REQ-022 IDLE/DONE + start SHALL clear txn_count, checksum and timeout_err, reload x=SEED, enter GAP; start in GAP/REQ SHALL be ignored.
REQ-023 GAP SHALL last exactly GAP cycles, then enter REQ.
REQ-024 On GAP->REQ SHALL compute a=xs(x), b=xs(a), c=xs(b) in one cycle; xs(v)= v^=v<<13; v^=v>>17; v^=v<<5, all 32-bit truncated; x<=c.
REQ-025 SHALL drive pcpi_insn=a with [31:25]=7'd1, [14]=0, [6:0]=7'b0110011; pcpi_rs1=b; pcpi_rs2=c.
REQ-026 pcpi_valid SHALL rise on REQ entry; insn/rs1/rs2 SHALL stay stable while valid is high.
REQ-027 pcpi_ready SHALL be ignored in the first valid cycle; it SHALL be sampled from the second valid cycle onward.
REQ-028 Ready sampled high SHALL drop valid the next cycle, increment txn_count, and, if pcpi_wr=1, set checksum<=rotl(checksum,1)^pcpi_rd.
REQ-029 Timer SHALL count REQ cycles with pcpi_wait=0; on reaching TIMEOUT without ready: drop valid, set timeout_err, increment txn_count, leave checksum unchanged.
REQ-030 Ready and timeout in the same cycle SHALL be handled as ready.
REQ-031 After a completed transaction: txn_count==NUM_TXN -> DONE, else GAP.
REQ-032 DONE SHALL drive done=1, busy=0; busy SHALL be 1 exactly in GAP/REQ.

Reset
REQ-033 resetn low SHALL asynchronously force IDLE, x=SEED, and all outputs to 0.
REQ-034 Reset mid-REQ SHALL drop pcpi_valid immediately with no count or checksum update.

Structure
REQ-035 SHALL place the state enum, opcode 7'b0110011, funct7 7'd1, and the xs() function in package pcpi_init_pkg.
REQ-036 SHALL use one sub-module, pcpi_xorshift32: a combinational three-step generator, instantiated once.

Verification
REQ-037 SEED=1, GAP=2: start -> first request pcpi_insn=0x02042033, valid 3 cycles after start.
REQ-038 Responder ready on valid's 2nd cycle, wr=1, rd=0x1 -> checksum=0x00000001, txn_count=1.
REQ-039 Responder ready in the first valid cycle only -> ignored; valid stays high.
REQ-040 TIMEOUT=4, ready never, wait=0 -> valid drops after 4 cycles; timeout_err=1; checksum unchanged.
REQ-041 pcpi_wait held high for 10 cycles, TIMEOUT=4 -> no timeout; ready later completes normally.
REQ-042 NUM_TXN=3, wr=0 -> done=1, txn_count=3, checksum=0; restart start clears and repeats identical insn sequence.

Source files
------------

// File: rtl/pcpi_init_pkg.sv
// Shared definitions for the PCPI traffic initiator: FSM states, instruction
// field constants and the xorshift32 step function.
package pcpi_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_REQ,
    ST_DONE
  } state_t;

  localparam logic [6:0] PCPI_OPCODE = 7'b0110011;
  localparam logic [6:0] PCPI_FUNCT7 = 7'd1;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // R-type word with funct7=1 and funct3[2]=0, so the request is always an M-extension op.
  function automatic logic [31:0] make_insn(input logic [31:0] a);
    return {PCPI_FUNCT7, a[24:15], 1'b0, a[13:7], PCPI_OPCODE};
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/pcpi_xorshift32.sv
// Combinational three-step xorshift32: produces the insn seed and both operands
// from the current generator state in a single cycle.
module pcpi_xorshift32
  import pcpi_init_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] c
);

  assign a = xs(x);
  assign b = xs(a);
  assign c = xs(b);

endmodule

// File: rtl/pcpi_initiator.sv
// PCPI request generator: issues NUM_TXN pseudo-random M-extension requests,
// each after GAP idle cycles, and folds the responder results into a checksum.
module pcpi_initiator
  import pcpi_init_pkg::*;
#(
  parameter int          NUM_TXN = 100,
  parameter int          GAP     = 10,
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] SEED    = 32'd314159265
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] txn_count,
  output logic [31:0] checksum
);

  localparam logic [31:0] GAP_LAST     = 32'(GAP - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [15:0] TXN_TOTAL    = 16'(NUM_TXN);

  state_t      state;
  logic [31:0] x_q;
  logic [31:0] gap_cnt;
  logic [31:0] timer;
  logic        first_cycle;

  logic [31:0] nxt_a;
  logic [31:0] nxt_b;
  logic [31:0] nxt_c;
  logic        ready_ok;
  logic        timed_out;
  logic [15:0] count_inc;

  pcpi_xorshift32 u_xs (
    .x (x_q),
    .a (nxt_a),
    .b (nxt_b),
    .c (nxt_c)
  );

  // Ready is only honoured from the second valid cycle; it wins over a coincident timeout.
  assign ready_ok  = pcpi_valid && !first_cycle && pcpi_ready;
  assign timed_out = pcpi_valid && !pcpi_wait && (timer == TIMEOUT_LAST);
  assign count_inc = txn_count + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      x_q         <= SEED;
      gap_cnt     <= '0;
      timer       <= '0;
      first_cycle <= 1'b0;
      pcpi_valid  <= 1'b0;
      pcpi_insn   <= '0;
      pcpi_rs1    <= '0;
      pcpi_rs2    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
      checksum    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            txn_count   <= '0;
            checksum    <= '0;
            timeout_err <= 1'b0;
            x_q         <= SEED;
            gap_cnt     <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            pcpi_valid  <= 1'b1;
            pcpi_insn   <= make_insn(nxt_a);
            pcpi_rs1    <= nxt_b;
            pcpi_rs2    <= nxt_c;
            x_q         <= nxt_c;
            first_cycle <= 1'b1;
            timer       <= '0;
            state       <= ST_REQ;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end

        ST_REQ: begin
          first_cycle <= 1'b0;
          if (ready_ok || timed_out) begin
            pcpi_valid <= 1'b0;
            txn_count  <= count_inc;
            if (ready_ok) begin
              if (pcpi_wr) begin
                checksum <= rotl1(checksum) ^ pcpi_rd;
              end
            end else begin
              timeout_err <= 1'b1;
            end
            if (count_inc == TXN_TOTAL) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end else if (!pcpi_wait) begin
            timer <= timer + 32'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_initiator.sv
// Self-checking bench for pcpi_initiator: table-driven responder behaviour with a
// scoreboard of expected requests, plus restart and mid-request reset sequences.
module tb_pcpi_initiator;

  localparam int          NUM_TXN = 3;
  localparam int          GAP     = 2;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] SEED    = 32'd1;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] txn_count;
  logic [31:0] checksum;

  pcpi_initiator #(
    .NUM_TXN (NUM_TXN),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT),
    .SEED    (SEED)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .txn_count   (txn_count),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ready_cycle;
    int          wait_cycles;
    logic        wr;
    logic [31:0] rd;
    logic        poke_start;
    logic        exp_timeout;
    int          exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } req_t;

  vec_t vecs[6];
  req_t sb[$];

  int          total = 0;
  int          bad   = 0;
  int          m_cnt;
  logic [31:0] m_chk;
  logic        m_err;

  function automatic logic [31:0] bxs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pushExpected();
    logic [31:0] x, a, b, c;
    req_t r;
    x = SEED;
    for (int i = 0; i < NUM_TXN; i++) begin
      a = bxs(x);
      b = bxs(a);
      c = bxs(b);
      r.insn = (a & 32'h01FF_BF80) | 32'h0200_0033;
      r.rs1  = b;
      r.rs2  = c;
      sb.push_back(r);
      x = c;
    end
  endtask

  task automatic doStart();
    int lat;
    pushExpected();
    m_cnt = 0;
    m_chk = '0;
    m_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done", 32'(done), 32'd0);
    checkOutput("start_count", 32'(txn_count), 32'd0);
    checkOutput("start_checksum", checksum, 32'd0);
    checkOutput("start_err", 32'(timeout_err), 32'd0);
    while (!pcpi_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("start_to_valid", 32'(lat), 32'd3);
  endtask

  task automatic applyStimulus(input vec_t v, input logic first_of_bench);
    int   guard;
    int   k;
    req_t e;
    guard = 0;
    while (!pcpi_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("valid_arrival", 32'(pcpi_valid), 32'd1);
    if (!pcpi_valid) return;
    checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{32'd0, 32'd0, 32'd0};
    if (first_of_bench) checkOutput("first_insn", pcpi_insn, 32'h0204_2033);
    k = 1;
    while (k < 100) begin
      checkOutput("insn", pcpi_insn, e.insn);
      checkOutput("rs1", pcpi_rs1, e.rs1);
      checkOutput("rs2", pcpi_rs2, e.rs2);
      pcpi_ready = (k == v.ready_cycle);
      pcpi_wait  = (k <= v.wait_cycles);
      pcpi_wr    = v.wr;
      pcpi_rd    = v.rd;
      if (v.poke_start && k == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (!pcpi_valid) break;
      k++;
    end
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    checkOutput("valid_len", 32'(k), 32'(v.exp_len));
    m_cnt++;
    if (v.exp_timeout) m_err = 1'b1;
    else if (v.wr) m_chk = {m_chk[30:0], m_chk[31]} ^ v.rd;
    checkOutput("txn_count", 32'(txn_count), 32'(m_cnt));
    checkOutput("checksum", checksum, m_chk);
    checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
    checkOutput("done", 32'(done), 32'(m_cnt == NUM_TXN));
    checkOutput("busy", 32'(busy), 32'(m_cnt != NUM_TXN));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;

    vecs[0] = '{2, 0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 2};
    vecs[1] = '{1, 0, 1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 4};
    vecs[2] = '{12, 10, 1'b1, 32'hA5A5_0000, 1'b0, 1'b0, 12};
    vecs[3] = '{2, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
    vecs[4] = '{3, 2, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 3};
    vecs[5] = '{4, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 4};

    resetn     = 1'b0;
    start      = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(pcpi_valid), 32'd0);
    checkOutput("rst_insn", pcpi_insn, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_count", 32'(txn_count), 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] run 1: ready, ignored first-cycle ready with timeout, long wait");
    doStart();
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i == 0);
    checkOutput("sb_left_run1", 32'(sb.size()), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("done_hold", 32'(done), 32'd1);

    $display("[TB] run 2: restart, wr=0, start ignored mid-request, ready at timeout");
    doStart();
    for (int i = 3; i < 6; i++) applyStimulus(vecs[i], 1'b0);
    checkOutput("sb_left_run2", 32'(sb.size()), 32'd0);

    $display("[TB] run 3: reset during request");
    doStart();
    guard = 0;
    while (!pcpi_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("r3_valid", 32'(pcpi_valid), 32'd1);
    @(negedge clk);
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'h0000_FFFF;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("r3_async_valid", 32'(pcpi_valid), 32'd0);
    checkOutput("r3_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    resetn     = 1'b1;
    checkOutput("r3_count", 32'(txn_count), 32'd0);
    checkOutput("r3_checksum", checksum, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("r3_idle_valid", 32'(pcpi_valid), 32'd0);
    checkOutput("r3_idle_busy", 32'(busy), 32'd0);
    checkOutput("r3_idle_done", 32'(done), 32'd0);
    sb.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
